// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalise/round pipeline.
// Provides default field widths, exponent constants, result/flag structs
// and a helper for the all-ones biased exponent of an arbitrary width.
package fp_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 23;
  localparam int GRD_W_DEF  = 3;

  localparam logic [EXP_W_DEF-1:0] EXP_ONES = '1;
  localparam logic [EXP_W_DEF-1:0] EXP_BIAS = EXP_W_DEF'((1 << (EXP_W_DEF - 1)) - 1);

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_DEF-1:0]  exp;
    logic [MANT_W_DEF-1:0] mant;
  } fp_word_t;

  typedef struct packed {
    logic zero;
    logic of;
    logic uf;
  } fp_flags_t;

  // All-ones biased exponent (infinity encoding) for an exponent of width w.
  function automatic int exp_ones(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter.
// Ports:
//   din   - WIDTH-bit input vector, MSB first
//   count - number of zeros above the highest set bit; WIDTH when din == 0
module lzc #(
  parameter  int WIDTH = 28,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise and round pipeline for raw FP add/sub results.
// Stage 1 counts leading zeros of the unnormalised mantissa; stage 2 shifts,
// adjusts the exponent, rounds (RNE or truncate) and classifies the result.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   in_valid / in_ready        - upstream handshake
//   in_sign, in_exp, in_mant   - raw result; in_mant = {carry, hidden, fraction, guard}
//   out_valid / out_ready      - downstream handshake
//   out_sign, out_exp, out_mant- normalised result (hidden bit dropped)
//   out_zero, out_of, out_uf   - zero, overflow (saturated to inf), underflow (flushed)
module fp_norm_round_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W     = EXP_W_DEF,
  parameter  int MANT_W    = MANT_W_DEF,
  parameter  int GRD_W     = GRD_W_DEF,
  parameter  bit ROUND_RNE = 1'b1,
  localparam int IN_W      = MANT_W + GRD_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [IN_W-1:0]   in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_of,
  output logic              out_uf
);

  localparam int LZ_W = $clog2(IN_W + 1);
  localparam int EW   = EXP_W + 2;
  // Bits below the fraction LSB after normalisation: guard at SW, sticky below.
  localparam int SW   = IN_W - 1 - MANT_W;

  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'(exp_ones(EXP_W));

  logic s1_adv, s2_adv;

  logic              s1_valid;
  logic              s1_sign;
  logic              s1_zero;
  logic [EXP_W-1:0]  s1_exp;
  logic [IN_W-2:0]   s1_mant;
  logic [LZ_W-1:0]   s1_lz;
  logic [LZ_W-1:0]   lz_d;

  assign s2_adv   = out_ready | ~out_valid;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  lzc #(.WIDTH(IN_W)) u_lzc (
    .din   (in_mant),
    .count (lz_d)
  );

  // The carry bit is only needed for the LZC and zero test; once lz is known
  // it is implied, so stage 1 keeps just the bits below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_lz    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_zero <= (in_mant == '0);
        s1_exp  <= in_exp;
        s1_mant <= in_mant[IN_W-2:0];
        s1_lz   <= lz_d;
      end
    end
  end

  logic [IN_W-1:0]       norm;
  logic [MANT_W-1:0]     frac;
  logic                  grd, sticky, inc;
  logic [MANT_W:0]       frac_sum;
  logic signed [EW-1:0]  e_pre, e_rnd;
  logic                  sign_d;
  logic [EXP_W-1:0]      exp_d;
  logic [MANT_W-1:0]     mant_d;
  fp_flags_t             flg_d;

  // Appending a zero and shifting left by lz covers both cases in one shifter:
  // lz=0 is the right shift by one (the old LSB lands in the sticky field),
  // lz>=1 is a left shift by lz-1. The hidden bit falls off the top.
  always_comb begin
    norm     = {s1_mant, 1'b0} << s1_lz;
    frac     = norm[IN_W-1 -: MANT_W];
    grd      = norm[SW];
    sticky   = |norm[SW-1:0];
    inc      = ROUND_RNE & grd & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {{MANT_W{1'b0}}, inc};
    e_pre    = EW'({2'b00, s1_exp}) + EW'(1) - EW'(s1_lz);
    // A carry out of the fraction leaves it all zeros; only the exponent moves.
    e_rnd    = e_pre + EW'(frac_sum[MANT_W]);

    sign_d = s1_sign;
    exp_d  = e_rnd[EXP_W-1:0];
    mant_d = frac_sum[MANT_W-1:0];
    flg_d  = '0;

    if (s1_zero) begin
      sign_d     = 1'b0;
      exp_d      = '0;
      mant_d     = '0;
      flg_d.zero = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      sign_d     = 1'b0;
      exp_d      = '0;
      mant_d     = '0;
      flg_d.zero = 1'b1;
      flg_d.uf   = 1'b1;
    end else if (e_rnd >= E_MAX) begin
      exp_d    = '1;
      mant_d   = '0;
      flg_d.of = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_zero  <= 1'b0;
      out_of    <= 1'b0;
      out_uf    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= sign_d;
        out_exp  <= exp_d;
        out_mant <= mant_d;
        out_zero <= flg_d.zero;
        out_of   <= flg_d.of;
        out_uf   <= flg_d.uf;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Self-checking bench for fp_norm_round_pipe. Two instances (RNE and
// truncate) share stimulus; results are compared against an arithmetic
// reference model or hand-derived constants.
module tb_fp_norm_round_pipe;

  localparam int IN_W = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, out_sign_a, out_zero_a, out_of_a, out_uf_a;
  logic [7:0]  out_exp_a;
  logic [22:0] out_mant_a;
  logic        in_ready_b, out_valid_b, out_sign_b, out_zero_b, out_of_b, out_uf_b;
  logic [7:0]  out_exp_b;
  logic [22:0] out_mant_b;

  fp_norm_round_pipe #(.EXP_W(8), .MANT_W(23), .GRD_W(3), .ROUND_RNE(1'b1)) dut_rne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sign(out_sign_a),
    .out_exp(out_exp_a), .out_mant(out_mant_a), .out_zero(out_zero_a),
    .out_of(out_of_a), .out_uf(out_uf_a)
  );

  fp_norm_round_pipe #(.EXP_W(8), .MANT_W(23), .GRD_W(3), .ROUND_RNE(1'b0)) dut_trc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sign(out_sign_b),
    .out_exp(out_exp_b), .out_mant(out_mant_b), .out_zero(out_zero_b),
    .out_of(out_of_b), .out_uf(out_uf_b)
  );

  // word = {sign, exp[7:0], mant[22:0], zero, of, uf}
  logic [34:0] word_a, word_b;
  assign word_a = {out_sign_a, out_exp_a, out_mant_a, out_zero_a, out_of_a, out_uf_a};
  assign word_b = {out_sign_b, out_exp_b, out_mant_b, out_zero_b, out_of_b, out_uf_b};

  int n_chk = 0;
  int n_pass = 0;
  int chk_idx = 0;
  logic [34:0] exp_a[$], exp_b[$], cap_a[$], cap_b[$];

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (out_valid_a) cap_a.push_back(word_a);
      if (out_valid_b) cap_b.push_back(word_b);
    end
  end

  function automatic logic [34:0] mkw(input logic s, input logic [7:0] e,
                                      input logic [22:0] f, input logic [2:0] fl);
    return {s, e, f, fl};
  endfunction

  // Value = mant * 2^(exp - bias - 26); locate the leading one, keep 24
  // significant bits, round the discarded remainder, then classify.
  function automatic logic [34:0] model(input logic s, input logic [7:0] ei,
                                        input logic [27:0] m, input bit rne);
    longint mv, q, rem, half;
    int p, sh, e;
    if (m == 28'd0) return mkw(1'b0, 8'd0, 23'd0, 3'b100);
    mv = longint'(m);
    p = 0;
    while ((mv >> (p + 1)) != 0) p++;
    e = int'(ei) + p - (IN_W - 2);
    if (p > 23) begin
      sh = p - 23;
      q = mv >> sh;
      rem = mv - (q << sh);
      half = 64'sd1 << (sh - 1);
      if (rne && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
    end else begin
      q = mv << (23 - p);
    end
    if (q == (64'sd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e <= 0) return mkw(1'b0, 8'd0, 23'd0, 3'b101);
    if (e >= 255) return mkw(s, 8'hFF, 23'd0, 3'b010);
    return mkw(s, e[7:0], q[22:0], 3'b000);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic s, input logic [7:0] e, input logic [27:0] m,
                           input logic [34:0] wa, input logic [34:0] wb, input bit rnd_rdy);
    bit acc;
    in_sign = s;
    in_exp = e;
    in_mant = m;
    in_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
      #1;
      acc = in_ready_a;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_a.push_back(wa);
        exp_b.push_back(wb);
        return;
      end
    end
    n_chk++;
    $display("FAIL send_beat timeout: in_ready stayed %b, required 1", in_ready_a);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (cap_a.size() >= exp_a.size() && cap_b.size() >= exp_b.size()) break;
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0)
      $display("FAIL reset_valid: got %b/%b want 0/0", out_valid_a, out_valid_b); else n_pass++;
    n_chk++; if (word_a !== 35'd0)
      $display("FAIL reset_word_rne: got %h want 0", word_a); else n_pass++;
    n_chk++; if (word_b !== 35'd0)
      $display("FAIL reset_word_trc: got %h want 0", word_b); else n_pass++;
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1)
      $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready_a, in_ready_b); else n_pass++;
    n_chk++; if (out_valid_a !== 1'b0)
      $display("FAIL reset_valid_after: got %b want 0", out_valid_a); else n_pass++;
  endtask

  typedef struct {
    logic s; logic [7:0] e; logic [27:0] m; logic [34:0] wa; logic [34:0] wb;
  } vec_t;

  task automatic test_directed();
    vec_t v[11];
    time t0;
    v[0]  = '{1'b0, 8'd127, 28'h8000000, mkw(0, 8'd128, 23'd0, 3'b000),      mkw(0, 8'd128, 23'd0, 3'b000)};
    v[1]  = '{1'b0, 8'd127, 28'h0400000, mkw(0, 8'd123, 23'd0, 3'b000),      mkw(0, 8'd123, 23'd0, 3'b000)};
    v[2]  = '{1'b0, 8'd3,   28'h0400000, mkw(0, 8'd0,   23'd0, 3'b101),      mkw(0, 8'd0,   23'd0, 3'b101)};
    v[3]  = '{1'b1, 8'd100, 28'h0000000, mkw(0, 8'd0,   23'd0, 3'b100),      mkw(0, 8'd0,   23'd0, 3'b100)};
    v[4]  = '{1'b0, 8'd254, 28'h8000000, mkw(0, 8'hFF,  23'd0, 3'b010),      mkw(0, 8'hFF,  23'd0, 3'b010)};
    v[5]  = '{1'b0, 8'd127, 28'h7FFFFFC, mkw(0, 8'd128, 23'd0, 3'b000),      mkw(0, 8'd127, 23'h7FFFFF, 3'b000)};
    v[6]  = '{1'b0, 8'd127, 28'h4000004, mkw(0, 8'd127, 23'd0, 3'b000),      mkw(0, 8'd127, 23'd0, 3'b000)};
    v[7]  = '{1'b1, 8'd127, 28'h400000C, mkw(1, 8'd127, 23'd2, 3'b000),      mkw(1, 8'd127, 23'd1, 3'b000)};
    v[8]  = '{1'b0, 8'd1,   28'h4000000, mkw(0, 8'd1,   23'd0, 3'b000),      mkw(0, 8'd1,   23'd0, 3'b000)};
    v[9]  = '{1'b0, 8'd0,   28'h4000000, mkw(0, 8'd0,   23'd0, 3'b101),      mkw(0, 8'd0,   23'd0, 3'b101)};
    v[10] = '{1'b1, 8'd254, 28'h7FFFFFC, mkw(1, 8'hFF,  23'd0, 3'b010),      mkw(1, 8'd254, 23'h7FFFFF, 3'b000)};

    out_ready = 1'b1;
    send_beat(v[0].s, v[0].e, v[0].m, v[0].wa, v[0].wb, 1'b0);
    in_valid = 1'b0;
    n_chk++; if (out_valid_a !== 1'b0)
      $display("FAIL latency_early: out_valid %b want 0 one cycle after accept", out_valid_a); else n_pass++;
    @(posedge clk);
    #1;
    n_chk++; if (out_valid_a !== 1'b1 || word_a !== v[0].wa)
      $display("FAIL latency_two: valid %b word %h want 1 %h", out_valid_a, word_a, v[0].wa); else n_pass++;

    t0 = $time;
    for (int i = 1; i < 11; i++) send_beat(v[i].s, v[i].e, v[i].m, v[i].wa, v[i].wb, 1'b0);
    n_chk++; if (($time - t0) != 100)
      $display("FAIL throughput: 10 beats took %0t want 100", $time - t0); else n_pass++;
    drain();

    n_chk++; if (cap_a.size() != exp_a.size() || cap_b.size() != exp_b.size())
      $display("FAIL directed_count: got %0d/%0d want %0d", cap_a.size(), cap_b.size(), exp_a.size()); else n_pass++;
    for (int i = chk_idx; i < exp_a.size(); i++) begin
      n_chk++; if (cap_a[i] !== exp_a[i])
        $display("FAIL directed_rne beat %0d: got %h want %h", i, cap_a[i], exp_a[i]); else n_pass++;
      n_chk++; if (cap_b[i] !== exp_b[i])
        $display("FAIL directed_trc beat %0d: got %h want %h", i, cap_b[i], exp_b[i]); else n_pass++;
    end
    chk_idx = exp_a.size();
  endtask

  task automatic rand_beat(output logic s, output logic [7:0] e, output logic [27:0] m);
    s = ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 3))
      0: e = 8'($urandom_range(0, 4));
      1: e = 8'($urandom_range(250, 255));
      default: e = 8'($urandom_range(0, 255));
    endcase
    case ($urandom_range(0, 4))
      0: m = 28'h4000004 | (28'($urandom()) & 28'h3FFFFF8);
      1: m = 28'h8000000 | 28'($urandom());
      default: m = 28'($urandom()) >> $urandom_range(0, 28);
    endcase
  endtask

  task automatic test_backpressure();
    logic s[4];
    logic [7:0] e[4];
    logic [27:0] m[4];
    logic [34:0] w0;
    for (int i = 0; i < 4; i++) rand_beat(s[i], e[i], m[i]);
    w0 = model(s[0], e[0], m[0], 1'b1);
    out_ready = 1'b0;
    send_beat(s[0], e[0], m[0], w0, model(s[0], e[0], m[0], 1'b0), 1'b0);
    send_beat(s[1], e[1], m[1], model(s[1], e[1], m[1], 1'b1), model(s[1], e[1], m[1], 1'b0), 1'b0);
    in_sign = s[2];
    in_exp = e[2];
    in_mant = m[2];
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (in_ready_a !== 1'b0)
        $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready_a); else n_pass++;
      n_chk++; if (out_valid_a !== 1'b1 || word_a !== w0)
        $display("FAIL bp_hold cycle %0d: valid %b word %h want 1 %h", c, out_valid_a, word_a, w0); else n_pass++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(s[2], e[2], m[2], model(s[2], e[2], m[2], 1'b1), model(s[2], e[2], m[2], 1'b0), 1'b0);
    send_beat(s[3], e[3], m[3], model(s[3], e[3], m[3], 1'b1), model(s[3], e[3], m[3], 1'b0), 1'b0);
    drain();

    n_chk++; if (cap_a.size() != exp_a.size() || cap_b.size() != exp_b.size())
      $display("FAIL bp_count: got %0d/%0d want %0d", cap_a.size(), cap_b.size(), exp_a.size()); else n_pass++;
    for (int i = chk_idx; i < exp_a.size(); i++) begin
      n_chk++; if (cap_a[i] !== exp_a[i])
        $display("FAIL bp_rne beat %0d: got %h want %h", i, cap_a[i], exp_a[i]); else n_pass++;
      n_chk++; if (cap_b[i] !== exp_b[i])
        $display("FAIL bp_trc beat %0d: got %h want %h", i, cap_b[i], exp_b[i]); else n_pass++;
    end
    chk_idx = exp_a.size();
  endtask

  task automatic test_back_to_back_random();
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        #1;
      end
      rand_beat(s, e, m);
      send_beat(s, e, m, model(s, e, m, 1'b1), model(s, e, m, 1'b0), 1'b1);
    end
    drain();

    n_chk++; if (cap_a.size() != exp_a.size() || cap_b.size() != exp_b.size())
      $display("FAIL random_count: got %0d/%0d want %0d", cap_a.size(), cap_b.size(), exp_a.size()); else n_pass++;
    for (int i = chk_idx; i < exp_a.size(); i++) begin
      n_chk++; if (cap_a[i] !== exp_a[i])
        $display("FAIL random_rne beat %0d: got %h want %h", i, cap_a[i], exp_a[i]); else n_pass++;
      n_chk++; if (cap_b[i] !== exp_b[i])
        $display("FAIL random_trc beat %0d: got %h want %h", i, cap_b[i], exp_b[i]); else n_pass++;
    end
    chk_idx = exp_a.size();
  endtask

  task automatic test_reset_midflight();
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_beat(s, e, m);
      send_beat(s, e, m, model(s, e, m, 1'b1), model(s, e, m, 1'b0), 1'b0);
    end
    in_valid = 1'b0;
    n_chk++; if (out_valid_a !== 1'b1)
      $display("FAIL midrst_prefill: out_valid %b want 1", out_valid_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0)
      $display("FAIL midrst_valid: got %b/%b want 0/0", out_valid_a, out_valid_b); else n_pass++;
    n_chk++; if ({out_zero_a, out_of_a, out_uf_a, out_zero_b, out_of_b, out_uf_b} !== 6'd0)
      $display("FAIL midrst_flags: got %b%b%b/%b%b%b want 0", out_zero_a, out_of_a, out_uf_a,
               out_zero_b, out_of_b, out_uf_b); else n_pass++;
    while (exp_a.size() > chk_idx) void'(exp_a.pop_back());
    while (exp_b.size() > chk_idx) void'(exp_b.pop_back());
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    n_chk++; if (out_valid_a !== 1'b0 || cap_a.size() != chk_idx)
      $display("FAIL midrst_quiet: valid %b captured %0d want 0 %0d", out_valid_a, cap_a.size(), chk_idx); else n_pass++;
    rand_beat(s, e, m);
    send_beat(s, e, m, model(s, e, m, 1'b1), model(s, e, m, 1'b0), 1'b0);
    drain();

    n_chk++; if (cap_a.size() != exp_a.size() || cap_b.size() != exp_b.size())
      $display("FAIL midrst_count: got %0d/%0d want %0d", cap_a.size(), cap_b.size(), exp_a.size()); else n_pass++;
    for (int i = chk_idx; i < exp_a.size(); i++) begin
      n_chk++; if (cap_a[i] !== exp_a[i])
        $display("FAIL midrst_rne beat %0d: got %h want %h", i, cap_a[i], exp_a[i]); else n_pass++;
      n_chk++; if (cap_b[i] !== exp_b[i])
        $display("FAIL midrst_trc beat %0d: got %h want %h", i, cap_b[i], exp_b[i]); else n_pass++;
    end
    chk_idx = exp_a.size();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_pipe.md
Name: fp_norm_round_pipe

Overview:
- Parametrised, pipelined successor to the combinational exponent/mantissa shifter in the Maxnet floating-point datapath.
- Takes the raw result of an FP add/sub: sign, biased exponent, and an unnormalised mantissa carrying a carry bit, hidden bit and guard bits.
- Normalises via leading-zero count and shift, adjusts the exponent, and rounds round-to-nearest-even or truncate.
- Flags zero, overflow and underflow.
- Sits between the FP adder core and the Maxnet compare/accumulate stage, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width (biased).
- MANT_W, 23, stored fraction width (hidden bit excluded).
- GRD_W, 3, extra low-order input bits below the fraction LSB.
- ROUND_RNE, 1, 1 = round-to-nearest-even, 0 = truncate.
- IN_W, MANT_W+GRD_W+2, derived input mantissa width: carry, hidden, fraction, guard.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sign  in  1  sign.
- in_exp  in  EXP_W  biased exponent referring to the hidden-bit position IN_W-2.
- in_mant  in  IN_W  unnormalised magnitude; bit IN_W-1 = carry, IN_W-2 = hidden.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  passed-through sign; forced 0 for a zero result.
- out_exp  out  EXP_W  normalised biased exponent.
- out_mant  out  MANT_W  normalised fraction (hidden bit dropped).
- out_zero  out  1  result is zero (input zero or flushed).
- out_of  out  1  overflow; result saturated to infinity.
- out_uf  out  1  underflow; result flushed to zero.

Behaviour:
- Clock and reset: one clock clk. rst_n is asynchronous, active-low.
- Reset state: all pipeline valids = 0. out_valid = 0. All out_* data and flags = 0. in_ready = 1 after reset release.
- Reset mid-operation: in-flight beats are discarded; nothing is emitted after release until new input arrives.
- Pipeline: 2 register stages, latency exactly 2 cycles with out_ready held high.
- Stage 1: LZC over in_mant from bit IN_W-1 gives lz (0..IN_W). Register sign, exp, mant, lz, and is_zero = (in_mant == 0).
- Stage 2: shift, exponent adjust, round, classify; registered outputs.
- Handshake:
  - A stage advances when it is empty or the stage after it advances; stage 2 advances when out_ready=1 or out_valid=0.
  - in_ready = stage-1 advance condition, combinational from out_ready through the stage valids (no skid buffer).
  - Transfer occurs only when valid && ready.
  - out_* are held stable while out_valid && !out_ready.
  - No beats are dropped or reordered. Throughput is 1 beat/cycle.
- Exponent arithmetic: signed, EXP_W+2 bits. e = in_exp + 1 - lz.
  - lz = 0: right shift by 1; the shifted-out bit joins sticky.
  - lz ≥ 1: left shift by lz-1, zero-filled.
- Rounding:
  - After the shift, hidden = top bit, fraction = next MANT_W bits, G = following bit, S = OR of all remaining bits.
  - RNE: increment when G & (S | fraction LSB).
  - Truncate: never increment.
  - If the increment carries out of the fraction: fraction = 0, e = e + 1.
- Classification, applied after rounding, in priority order:
  1. is_zero: out_zero=1, exp=0, mant=0, sign=0, no flags.
  2. e ≤ 0: underflow flush. out_uf=1, out_zero=1, exp=0, mant=0, sign=0. No denormals.
  3. e ≥ 2^EXP_W-1: out_of=1, exp all ones, mant=0, sign preserved.
  4. Otherwise: normal result.
- Flags are mutually exclusive, except that out_uf implies out_zero.

Decomposition:
- Shared package fp_pkg:
  - EXP_W/MANT_W defaults.
  - Exponent-all-ones and bias constants.
  - Packed result struct (sign, exp, mant).
  - Flag struct (zero, of, uf).
- Sub-module lzc: parametrised leading-zero counter, WIDTH input, $clog2(WIDTH+1) output, count = WIDTH for all-zero input. Instantiated in stage 1.

Test Plan (defaults, IN_W=28, out_ready=1 unless stated):
- Carry normalise: exp=127, mant=28'h8000000 -> after 2 cycles exp=128, mant=0, no flags.
- Left shift: exp=127, mant=28'h0400000 (lz=5) -> exp=123, mant=0. Same mant with exp=3 -> out_uf=1, out_zero=1, exp=0.
- Zero input and overflow:
  - mant=0, sign=1 -> out_zero=1, sign=0, out_uf=0.
  - exp=254, mant=28'h8000000 -> exp=8'hFF, mant=0, out_of=1.
- Rounding:
  - exp=127, mant=28'h7FFFFFC, RNE -> rounding carry gives exp=128, mant=0.
  - Same beat with ROUND_RNE=0 -> exp=127, mant=23'h7FFFFF.
  - mant=28'h4000004 (tie, LSB 0) -> exp=127, mant=0.
- Backpressure:
  - Send 4 back-to-back beats with out_ready=0 -> in_ready drops after 2 beats accepted; out_* stable.
  - Release out_ready -> all 4 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 2 beats in the pipe -> out_valid=0 and flags=0 immediately (async); nothing emitted after release until new input.
